// File: rtl/seed_pkg.sv
// Shared constants, lane-placement helper and FIFO entry layout for the seed packer.
package seed_pkg;

    localparam int SEED_IN_W  = 32;
    localparam int SEED_RATIO = 8;

    typedef struct packed {
        logic                             partial;
        logic [SEED_IN_W*SEED_RATIO-1:0]  data;
    } seed_entry_t;

    // Bit offset of lane k inside the packed output word.
    function automatic int lane_lsb(input int k, input int ratio, input bit msb_first,
                                    input int in_w = SEED_IN_W);
        return msb_first ? (ratio - 1 - k) * in_w : k * in_w;
    endfunction

endpackage

// File: rtl/seed_out_fifo.sv
// Small circular output buffer; head is read combinationally so data is ready with valid.
module seed_out_fifo #(
    parameter int W     = 257,
    parameter int DEPTH = 2
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         push,
    input  logic [W-1:0]                 wdata,
    input  logic                         pop,
    output logic [W-1:0]                 head,
    output logic [$clog2(DEPTH+1)-1:0]   level,
    output logic                         full,
    output logic                         empty
);

    localparam int PW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int LV_W = $clog2(DEPTH + 1);
    localparam logic [PW-1:0]   LAST_PTR = PW'(DEPTH - 1);
    localparam logic [LV_W-1:0] FULL_LVL = LV_W'(DEPTH);

    logic [W-1:0]    mem [DEPTH];
    logic [PW-1:0]   wr_ptr_reg;
    logic [PW-1:0]   rd_ptr_reg;
    logic [LV_W-1:0] level_reg;
    logic            push_en;
    logic            pop_en;

    assign full    = (level_reg == FULL_LVL);
    assign empty   = (level_reg == '0);
    assign push_en = push && !full;
    assign pop_en  = pop && !empty;
    assign head    = mem[rd_ptr_reg];
    assign level   = level_reg;

    always_ff @(posedge clk) begin
        if (push_en) begin
            mem[wr_ptr_reg] <= wdata;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            level_reg  <= '0;
        end else begin
            if (push_en) begin
                wr_ptr_reg <= (wr_ptr_reg == LAST_PTR) ? '0 : wr_ptr_reg + PW'(1);
            end
            if (pop_en) begin
                rd_ptr_reg <= (rd_ptr_reg == LAST_PTR) ? '0 : rd_ptr_reg + PW'(1);
            end
            case ({push_en, pop_en})
                2'b10:   level_reg <= level_reg + LV_W'(1);
                2'b01:   level_reg <= level_reg - LV_W'(1);
                default: level_reg <= level_reg;
            endcase
        end
    end

endmodule

// File: rtl/seed_packer.sv
// Narrow-to-wide seed packer: gathers RATIO words into one wide word, with flush of
// zero-padded partial words and a small output FIFO.
module seed_packer
    import seed_pkg::*;
#(
    parameter int IN_W      = SEED_IN_W,
    parameter int RATIO     = SEED_RATIO,
    parameter int OUT_DEPTH = 2,
    parameter bit MSB_FIRST = 1'b0
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             in_valid,
    output logic                             in_ready,
    input  logic [IN_W-1:0]                  in_data,
    input  logic                             flush,
    output logic                             out_valid,
    input  logic                             out_ready,
    output logic [IN_W*RATIO-1:0]            out_data,
    output logic                             out_partial,
    output logic [$clog2(RATIO)-1:0]         lane_count,
    output logic [$clog2(OUT_DEPTH+1)-1:0]   out_level
);

    localparam int OUT_W = IN_W * RATIO;
    localparam int LC_W  = $clog2(RATIO);
    localparam logic [LC_W-1:0] LAST_LANE = LC_W'(RATIO - 1);

    localparam logic [0:0] ST_IDLE    = 1'b0;
    localparam logic [0:0] ST_PENDING = 1'b1;

    logic [OUT_W-1:0] acc_reg;
    logic [OUT_W-1:0] acc_next;
    logic [OUT_W-1:0] acc_placed;
    logic [LC_W-1:0]  lane_reg;
    logic [LC_W-1:0]  lane_next;
    logic [0:0]       state_reg;
    logic [0:0]       state_next;

    logic             flush_pending;
    logic             last_lane;
    logic             accept;
    logic             commit_full;
    logic             flush_push;
    logic             fifo_push;
    logic             fifo_full;
    logic             fifo_empty;
    logic [OUT_W:0]   fifo_wdata;
    logic [OUT_W:0]   fifo_head;

    // Accumulator with the incoming word dropped into the current lane.
    for (genvar gi = 0; gi < RATIO; gi++) begin : g_lane
        localparam int LSB = lane_lsb(gi, RATIO, MSB_FIRST, IN_W);
        assign acc_placed[LSB +: IN_W] = (lane_reg == LC_W'(gi)) ? in_data
                                                                  : acc_reg[LSB +: IN_W];
    end

    assign flush_pending = (state_reg == ST_PENDING);
    assign last_lane     = (lane_reg == LAST_LANE);
    assign in_ready      = !flush_pending && (!last_lane || !fifo_full);
    assign accept        = in_valid && in_ready;
    assign commit_full   = accept && last_lane;
    assign flush_push    = flush_pending && !fifo_full;
    assign fifo_push     = commit_full || flush_push;
    // Accepts are blocked while pending, so the two push sources never coincide.
    assign fifo_wdata    = commit_full ? {1'b0, acc_placed} : {1'b1, acc_reg};

    always_comb begin
        state_next = state_reg;
        lane_next  = lane_reg;
        acc_next   = acc_reg;
        if (fifo_push) begin
            lane_next  = '0;
            acc_next   = '0;
            state_next = ST_IDLE;
        end else if (accept) begin
            lane_next = lane_reg + LC_W'(1);
            acc_next  = acc_placed;
        end
        // A flush riding on a word-completing beat is absorbed by the full commit.
        if (flush && (state_reg == ST_IDLE) && !commit_full && (accept || (lane_reg != '0))) begin
            state_next = ST_PENDING;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc_reg   <= '0;
            lane_reg  <= '0;
            state_reg <= ST_IDLE;
        end else begin
            acc_reg   <= acc_next;
            lane_reg  <= lane_next;
            state_reg <= state_next;
        end
    end

    seed_out_fifo #(
        .W     (OUT_W + 1),
        .DEPTH (OUT_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (fifo_push),
        .wdata (fifo_wdata),
        .pop   (out_ready),
        .head  (fifo_head),
        .level (out_level),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign out_valid   = !fifo_empty;
    assign out_data    = fifo_empty ? '0 : fifo_head[OUT_W-1:0];
    assign out_partial = !fifo_empty && fifo_head[OUT_W];
    assign lane_count  = lane_reg;

endmodule

// File: tb/tb_seed_packer.sv
// Bench for seed_packer: LSB-first and MSB-first instances share stimulus and are
// compared every cycle against a queue-based model of accepted words and FIFO contents.
module tb_seed_packer;

    localparam int IN_W  = 32;
    localparam int RATIO = 8;
    localparam int DEPTH = 2;
    localparam int OUT_W = IN_W * RATIO;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             iv = 1'b0;
    logic             fl = 1'b0;
    logic             ordy = 1'b0;
    logic [IN_W-1:0]  id = '0;

    logic             rdy0, rdy1, ov0, ov1, op0, op1;
    logic [OUT_W-1:0] od0, od1;
    logic [2:0]       lc0, lc1;
    logic [1:0]       lv0, lv1;

    always #5 clk = ~clk;

    seed_packer #(.IN_W(IN_W), .RATIO(RATIO), .OUT_DEPTH(DEPTH), .MSB_FIRST(1'b0)) u_lsb (
        .clk(clk), .reset(reset), .in_valid(iv), .in_ready(rdy0), .in_data(id),
        .flush(fl), .out_valid(ov0), .out_ready(ordy), .out_data(od0),
        .out_partial(op0), .lane_count(lc0), .out_level(lv0)
    );

    seed_packer #(.IN_W(IN_W), .RATIO(RATIO), .OUT_DEPTH(DEPTH), .MSB_FIRST(1'b1)) u_msb (
        .clk(clk), .reset(reset), .in_valid(iv), .in_ready(rdy1), .in_data(id),
        .flush(fl), .out_valid(ov1), .out_ready(ordy), .out_data(od1),
        .out_partial(op1), .lane_count(lc1), .out_level(lv1)
    );

    typedef struct {
        bit               partial;
        logic [OUT_W-1:0] d_lsb;
        logic [OUT_W-1:0] d_msb;
    } ent_t;

    logic [IN_W-1:0] grp[$];
    ent_t            fq[$];
    bit              pend = 1'b0;

    int n_tests = 0;
    int n_fail  = 0;

    function automatic bit m_ready();
        return !pend && (grp.size() != RATIO - 1 || fq.size() != DEPTH);
    endfunction

    function automatic ent_t make_ent(bit p);
        ent_t e;
        e.partial = p;
        e.d_lsb   = '0;
        e.d_msb   = '0;
        foreach (grp[k]) begin
            e.d_lsb[k*IN_W +: IN_W]           = grp[k];
            e.d_msb[(RATIO-1-k)*IN_W +: IN_W] = grp[k];
        end
        return e;
    endfunction

    task automatic chk(input string name, input logic [OUT_W-1:0] act, input logic [OUT_W-1:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_all();
        chk("in_ready_lsb", OUT_W'(rdy0), OUT_W'(m_ready()));
        chk("in_ready_msb", OUT_W'(rdy1), OUT_W'(m_ready()));
        chk("lane_count", OUT_W'(lc0), OUT_W'(grp.size()));
        chk("lane_count_msb", OUT_W'(lc1), OUT_W'(grp.size()));
        chk("out_level", OUT_W'(lv0), OUT_W'(fq.size()));
        chk("out_level_msb", OUT_W'(lv1), OUT_W'(fq.size()));
        chk("out_valid", OUT_W'(ov0), OUT_W'(fq.size() != 0));
        chk("out_valid_msb", OUT_W'(ov1), OUT_W'(fq.size() != 0));
        if (fq.size() != 0) begin
            chk("out_data_lsb", od0, fq[0].d_lsb);
            chk("out_data_msb", od1, fq[0].d_msb);
            chk("out_partial", OUT_W'(op0), OUT_W'(fq[0].partial));
            chk("out_partial_msb", OUT_W'(op1), OUT_W'(fq[0].partial));
        end
    endtask

    // Advance the model by one clock edge using the inputs that were applied.
    task automatic model_update();
        bit rdy;
        bit can_flush;
        rdy       = m_ready();
        can_flush = pend && (fq.size() < DEPTH);
        if (ordy && fq.size() > 0) void'(fq.pop_front());
        if (can_flush) begin
            fq.push_back(make_ent(1'b1));
            grp.delete();
            pend = 1'b0;
        end else if (iv && rdy) begin
            grp.push_back(id);
            if (grp.size() == RATIO) begin
                fq.push_back(make_ent(1'b0));
                grp.delete();
            end else if (fl) begin
                pend = 1'b1;
            end
        end else if (fl && !pend && grp.size() > 0) begin
            pend = 1'b1;
        end
    endtask

    task automatic step(input logic v, input logic [IN_W-1:0] d, input logic f, input logic r);
        iv = v; id = d; fl = f; ordy = r;
        #1;
        check_all();
        @(posedge clk);
        model_update();
        @(negedge clk);
    endtask

    task automatic send(input logic [IN_W-1:0] d, input logic f, input logic r);
        int guard;
        guard = 0;
        while (!m_ready() && guard < 64) begin
            step(1'b0, '0, 1'b0, r);
            guard++;
        end
        if (guard >= 64) begin
            chk("send_timeout", OUT_W'(guard), OUT_W'(0));
        end else begin
            step(1'b1, d, f, r);
        end
    endtask

    task automatic chk_reset_values();
        chk("rst_in_ready", OUT_W'(rdy0), OUT_W'(1));
        chk("rst_in_ready_msb", OUT_W'(rdy1), OUT_W'(1));
        chk("rst_lane_count", OUT_W'(lc0), '0);
        chk("rst_out_level", OUT_W'(lv0), '0);
        chk("rst_out_valid", OUT_W'(ov0), '0);
        chk("rst_out_partial", OUT_W'(op0), '0);
        chk("rst_out_data", od0, '0);
        chk("rst_out_valid_msb", OUT_W'(ov1), '0);
        chk("rst_out_data_msb", od1, '0);
    endtask

    task automatic drain();
        for (int i = 0; i < 4; i++) step(1'b0, '0, 1'b0, 1'b1);
    endtask

    initial begin
        logic [OUT_W-1:0] lit;

        #2;
        chk_reset_values();
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;

        // Words 0..7 back-to-back.
        for (int k = 0; k < RATIO; k++) send(IN_W'(k), 1'b0, 1'b1);
        lit = 256'h00000007_00000006_00000005_00000004_00000003_00000002_00000001_00000000;
        chk("t1_valid", OUT_W'(ov0), OUT_W'(1));
        chk("t1_lsb_word", od0, lit);
        chk("t1_partial", OUT_W'(op0), '0);
        chk("t1_model_size", OUT_W'(fq.size()), OUT_W'(1));
        if (fq.size() != 0) chk("t1_model_lsb", fq[0].d_lsb, lit);
        lit = 256'h00000000_00000001_00000002_00000003_00000004_00000005_00000006_00000007;
        chk("t1_msb_word", od1, lit);
        if (fq.size() != 0) chk("t1_model_msb", fq[0].d_msb, lit);
        drain();

        // Three words then a flush pulse.
        send(32'hA, 1'b0, 1'b0);
        send(32'hB, 1'b0, 1'b0);
        send(32'hC, 1'b0, 1'b0);
        step(1'b0, '0, 1'b1, 1'b0);
        step(1'b0, '0, 1'b0, 1'b0);
        lit = 256'h0000000C_0000000B_0000000A;
        chk("t2_partial_lsb", od0, lit);
        lit = 256'h0000000A_0000000B_0000000C_00000000_00000000_00000000_00000000_00000000;
        chk("t2_partial_msb", od1, lit);
        chk("t2_partial_flag", OUT_W'(op0), OUT_W'(1));
        chk("t2_lane_zero", OUT_W'(lc0), '0);
        drain();

        // Back-pressure: 23 words with the consumer stalled, then release.
        for (int k = 0; k < 23; k++) send(32'h100 + IN_W'(k), 1'b0, 1'b0);
        chk("t3_in_ready_low", OUT_W'(rdy0), '0);
        chk("t3_lane_7", OUT_W'(lc0), OUT_W'(7));
        chk("t3_level_full", OUT_W'(lv0), OUT_W'(2));
        send(32'h117, 1'b0, 1'b1);
        drain();

        // Flush together with the word-completing beat.
        for (int k = 0; k < RATIO - 1; k++) send(32'h300 + IN_W'(k), 1'b0, 1'b0);
        send(32'h307, 1'b1, 1'b0);
        step(1'b0, '0, 1'b0, 1'b0);
        step(1'b0, '0, 1'b0, 1'b0);
        chk("t4_single_word", OUT_W'(lv0), OUT_W'(1));
        chk("t4_full_flag", OUT_W'(op0), '0);
        chk("t4_lane_zero", OUT_W'(lc0), '0);
        drain();

        // Asynchronous reset in the middle of a word.
        for (int k = 0; k < RATIO + 5; k++) send(32'h400 + IN_W'(k), 1'b0, 1'b0);
        chk("t5_lane_5", OUT_W'(lc0), OUT_W'(5));
        chk("t5_level_1", OUT_W'(lv0), OUT_W'(1));
        #2;
        reset = 1'b1;
        #1;
        chk_reset_values();
        grp.delete();
        fq.delete();
        pend = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        for (int k = 0; k < RATIO; k++) send(32'h500 + IN_W'(k), 1'b0, 1'b1);
        chk("t5_clean_word", od0[63:0], 64'h00000501_00000500);
        drain();

        // Randomised traffic with varying consumer pressure.
        for (int c = 0; c < 3000; c++) begin
            logic r;
            if ((c / 200) % 2 == 0) r = ($urandom_range(0, 3) != 0);
            else                    r = ($urandom_range(0, 4) == 0);
            step(($urandom_range(0, 3) != 0), $urandom, ($urandom_range(0, 11) == 0), r);
        end
        drain();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/seed_packer.md
# seed_packer

Parametrised narrow-to-wide seed packer for the AES-256 datapath. It collects `RATIO` input words of `IN_W` bits into one `IN_W*RATIO`-bit output word, with programmable lane order. Results are buffered in a small output FIFO, and both sides use valid/ready handshakes. A flush command emits a zero-padded partial word. It sits between the 32-bit host/seed interface and the 256-bit key-load port of the AES core.

## Interface
Parameters:
- `IN_W`, 32, input word width in bits.
- `RATIO`, 8, input words per output word, ≥2; `OUT_W = IN_W*RATIO`.
- `OUT_DEPTH`, 2, output FIFO entries, power of 2, 1..16.
- `MSB_FIRST`, 0, lane order: 0 puts first word in the LSBs, 1 puts it in the MSBs.

Ports:
- `clk`  in  1  single clock; all logic on rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `in_valid`  in  1  input word present.
- `in_ready`  out  1  block can accept a word this cycle.
- `in_data`  in  `IN_W`  input word.
- `flush`  in  1  single-cycle pulse: commit the partial accumulator.
- `out_valid`  out  1  FIFO head valid.
- `out_ready`  in  1  consumer takes head.
- `out_data`  out  `OUT_W`  FIFO head word.
- `out_partial`  out  1  head word was produced by flush (zero-padded).
- `lane_count`  out  `$clog2(RATIO)`  number of lanes filled in the accumulator.
- `out_level`  out  `$clog2(OUT_DEPTH+1)`  occupied FIFO entries.

## Operation
- Accept is `in_valid && in_ready`. The word is written to lane `lane_count`, then `lane_count++`.
- Lane placement:
  - `MSB_FIRST=0`: bits `[k*IN_W +: IN_W]`.
  - `MSB_FIRST=1`: bits `[(RATIO-1-k)*IN_W +: IN_W]`.
- Commit on the last lane (`lane_count==RATIO-1`):
  - Accepting this word pushes the completed word (`partial=0`) into the FIFO.
  - `lane_count` wraps to 0 and the accumulator clears to 0.
- `in_ready` rules:
  - `in_ready = !flush_pending && (lane_count != RATIO-1 || out_level != OUT_DEPTH)`.
  - It never depends combinationally on `out_ready`. A pop does not free space for a push until the next cycle.
- Flush:
  - Sets `flush_pending` only if `lane_count>0`, or a beat is accepted in the same cycle that does not complete a word.
  - While `flush_pending` is set and FIFO has space: push the accumulator, with unwritten lanes = 0 and `partial=1`. Then clear `lane_count`, the accumulator and `flush_pending`.
  - Flush with `lane_count==0` and no beat accepted is ignored.
  - Flush in the same cycle as a word-completing beat is ignored; the normal full commit occurs instead.
  - While `flush_pending` is set, `in_ready=0`.
- Output FIFO:
  - Circular buffer with read/write pointers wrapping modulo `OUT_DEPTH`.
  - Pop on `out_valid && out_ready`.
  - Simultaneous push and pop leaves `out_level` unchanged.
  - Push when full cannot occur by construction. Pop when empty is ignored.
- Reset values (asynchronous):
  - `lane_count=0`, `out_level=0`, `out_valid=0`, `out_partial=0`, `flush_pending=0`.
  - `in_ready=1`, accumulator=0, `out_data=0`, pointers=0.
  - Asserting reset mid-accumulation discards all partial and buffered data.

## Timing
- Word accepted at edge N is visible in `lane_count` after edge N.
- A committing beat at edge N gives `out_valid=1` after edge N, with `out_data` and `out_partial` valid in the same cycle. Latency is 1 cycle from the last beat.
- Flush pulse at edge N with FIFO space gives the partial word at the head after edge N+1, because `flush_pending` occupies one cycle.
- Sustained throughput is 1 input word per cycle when `OUT_DEPTH≥2` or the consumer pops each word within `RATIO-1` cycles.
- `out_data` stays stable while `out_valid && !out_ready`.

## Structure
- Package `seed_pkg`:
  - Default constants `SEED_IN_W=32`, `SEED_RATIO=8`.
  - Function `lane_lsb(k, ratio, msb_first)` returning the bit offset.
  - Typedef for a FIFO entry `{partial, data}`.
- Sub-module `seed_out_fifo`:
  - Parametrised (`W=OUT_W+1`, `DEPTH`) circular buffer.
  - Ports: push, pop, head, level, full, empty.
- The top level holds the accumulator, lane counter and flush FSM (IDLE/PENDING).

## Test plan
- `IN_W=32`, `RATIO=8`, `MSB_FIRST=0`; feed words `0x0..0x7` back-to-back, `out_ready=1` → one word `0x00000007_…_00000001_00000000`, `out_partial=0`, `out_valid` the cycle after the 8th accept.
- Same stimulus with `MSB_FIRST=1` → `out_data=0x00000000_00000001_…_00000007`.
- 3 words `0xA,0xB,0xC` then flush → `out_partial=1`, `out_data[95:0]=0xC_B_A` lanes, upper 160 bits 0, `lane_count` returns to 0.
- `OUT_DEPTH=2`, `out_ready=0`, stream 24 words:
  - `in_ready` drops at `lane_count=7` with `out_level=2`.
  - Raise `out_ready` → words drain in order, `in_ready` reasserts the cycle after the first pop.
  - No data is lost.
- Flush on the same cycle as the 8th word → exactly one full word with `partial=0`; no extra partial word.
- Assert `reset` mid-word (`lane_count=5`, `out_level=1`) → all outputs at reset values immediately, without waiting for an edge. The next 8 words produce a clean word.
